// File: rtl/scan_mux_n_to_1_if.sv
// rtl/scan_mux_n_to_1_if.sv - control, data and output handshake bundle for scan_mux_n_to_1
// SCAN_MASK_EN adds the ch_mask channel-enable vector.
interface scan_mux_n_to_1_if #(
  parameter int N_CH = 8,
  parameter int W    = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic              en;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [N_CH*W-1:0] in_data;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              out_err;
`ifdef SCAN_MASK_EN
  logic [N_CH-1:0]   ch_mask;

  modport master (
    output en, mode, sel, in_data, out_ready, ch_mask,
    input  out_data, out_ch, out_valid, out_err
  );
  modport slave (
    input  en, mode, sel, in_data, out_ready, ch_mask,
    output out_data, out_ch, out_valid, out_err
  );
`else
  modport master (
    output en, mode, sel, in_data, out_ready,
    input  out_data, out_ch, out_valid, out_err
  );
  modport slave (
    input  en, mode, sel, in_data, out_ready,
    output out_data, out_ch, out_valid, out_err
  );
`endif
endinterface

// File: rtl/scan_mux_n_to_1.sv
// rtl/scan_mux_n_to_1.sv - N-channel registered mux with direct-select / round-robin scan and valid/ready output
// Optional SCAN_MASK_EN: per-channel enable mask for scan and direct select.
module scan_mux_n_to_1 #(
  parameter int N_CH = 8,
  parameter int W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  scan_mux_n_to_1_if.slave    bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [N_CH-1:0]  mask;
  logic             load, accept;
  logic [W-1:0]     sel_data, scan_data;
  logic             sel_legal;
  logic             hit_hi, hit_lo, scan_ok;
  logic [SEL_W-1:0] ch_hi, ch_lo, scan_ch, ptr_next;

`ifdef SCAN_MASK_EN
  assign mask = bus.ch_mask;
`else
  assign mask = '1;
`endif

  // Out-of-range selects never match, so they fall out as illegal.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_data  = bus.in_data[i*W +: W];
        sel_legal = mask[i];
      end
    end
  end

  // Circular search from ptr: lowest enabled index >= ptr, else lowest below ptr.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    ch_hi  = '0;
    ch_lo  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        if (SEL_W'(i) >= ptr_q) begin
          hit_hi = 1'b1;
          ch_hi  = SEL_W'(i);
        end else begin
          hit_lo = 1'b1;
          ch_lo  = SEL_W'(i);
        end
      end
    end
    scan_ok = hit_hi | hit_lo;
    scan_ch = hit_hi ? ch_hi : ch_lo;
  end

  always_comb begin
    scan_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (scan_ch == SEL_W'(i)) scan_data = bus.in_data[i*W +: W];
    end
  end

  assign ptr_next = (scan_ch == SEL_W'(N_CH - 1)) ? '0 : scan_ch + SEL_W'(1);
  assign accept   = (state_q == FULL) && bus.out_ready;
  assign load     = bus.en && ((state_q == EMPTY) || bus.out_ready)
                    && (!bus.mode || scan_ok);

  always_comb begin
    ptr_d = ptr_q;
    if (bus.mode) begin
      ch_d   = scan_ch;
      data_d = scan_data;
      err_d  = 1'b0;
      ptr_d  = ptr_next;
    end else begin
      ch_d   = bus.sel;
      data_d = sel_legal ? sel_data : '0;
      err_d  = !sel_legal;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (!bus.en || (accept && !load)) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!bus.en) begin
        data_q <= '0;
        err_q  <= 1'b0;
      end else if (load) begin
        data_q <= data_d;
        ch_q   <= ch_d;
        err_q  <= err_d;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = (state_q == FULL);
endmodule

// File: tb/tb_scan_mux_n_to_1.sv
// tb/tb_scan_mux_n_to_1.sv - scoreboard bench for scan_mux_n_to_1 (N_CH=8 and N_CH=6 instances)
module tb_scan_mux_n_to_1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_mux_n_to_1_if #(.N_CH(8), .W(8)) b8 ();
  scan_mux_n_to_1_if #(.N_CH(6), .W(8)) b6 ();

  scan_mux_n_to_1 #(.N_CH(8), .W(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b8));
  scan_mux_n_to_1 #(.N_CH(6), .W(8)) dut6 (.clk_i(clk), .rst_i(rst), .bus(b6));

  typedef struct {
    logic [7:0] d;
    logic [2:0] ch;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] ch, input logic err);
    exp_t e;
    e.d = d; e.ch = ch; e.err = err;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && b8.out_valid && b8.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got data %0h ch %0d err %0b, none expected",
                 b8.out_data, b8.out_ch, b8.out_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (b8.out_data !== e.d || b8.out_ch !== e.ch || b8.out_err !== e.err) begin
          errors++;
          $display("FAIL word: got data %0h ch %0d err %0b expected data %0h ch %0d err %0b",
                   b8.out_data, b8.out_ch, b8.out_err, e.d, e.ch, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) b8.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) b6.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    b8.en = 1'b1; b8.mode = 1'b0; b8.sel = 3'd0; b8.out_ready = 1'b1;
    b6.en = 1'b1; b6.mode = 1'b0; b6.sel = 3'd7; b6.out_ready = 1'b1;
`ifdef SCAN_MASK_EN
    b8.ch_mask = 8'hFF;
    b6.ch_mask = 6'h3F;
`endif
    rst = 1'b1;
    step(2);
    chk("rst_valid", 32'(b8.out_valid), 32'd0);
    chk("rst_data",  32'(b8.out_data),  32'd0);
    chk("rst_ch",    32'(b8.out_ch),    32'd0);
    chk("rst_err",   32'(b8.out_err),   32'd0);

    // Direct select of channel 5
    rst = 1'b0;
    b8.sel = 3'd5;
    push(8'hA5, 3'd5, 1'b0);
    step(1);
    chk("n6_illegal_valid", 32'(b6.out_valid), 32'd1);
    chk("n6_illegal_err",   32'(b6.out_err),   32'd1);
    chk("n6_illegal_data",  32'(b6.out_data),  32'd0);
    chk("n6_illegal_ch",    32'(b6.out_ch),    32'd7);
    b6.sel = 3'd4;

    // Scan from reset pointer: 0..7,0,1
    b8.mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(8'hA0 + 8'(k % 8), 3'(k % 8), 1'b0);
      step(1);
      if (k == 0) begin
        chk("n6_legal_data", 32'(b6.out_data), 32'hA4);
        chk("n6_legal_err",  32'(b6.out_err),  32'd0);
      end
    end

    // Continue to channel 3, then stall four cycles
    push(8'hA2, 3'd2, 1'b0); step(1);
    push(8'hA3, 3'd3, 1'b0); step(1);
    b8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("stall_data", 32'(b8.out_data), 32'hA3);
    end
    chk("stall_valid", 32'(b8.out_valid), 32'd1);
    b8.out_ready = 1'b1;
    push(8'hA4, 3'd4, 1'b0); step(1);
    push(8'hA5, 3'd5, 1'b0); step(1);
    push(8'hA6, 3'd6, 1'b0); step(1);

    // Disable mid-scan at channel 6, then resume at 7
    b8.en = 1'b0;
    step(1);
    chk("dis_valid", 32'(b8.out_valid), 32'd0);
    chk("dis_data",  32'(b8.out_data),  32'd0);
    chk("dis_ch",    32'(b8.out_ch),    32'd6);
    b8.en = 1'b1;
    push(8'hA7, 3'd7, 1'b0); step(1);
    push(8'hA0, 3'd0, 1'b0); step(1);

    // Pointer holds across a direct-mode excursion
    b8.mode = 1'b0; b8.sel = 3'd2;
    push(8'hA2, 3'd2, 1'b0); step(1);
    b8.mode = 1'b1;
    push(8'hA1, 3'd1, 1'b0); step(1);

`ifdef SCAN_MASK_EN
    b8.ch_mask = 8'b0010_0100;
    push(8'hA2, 3'd2, 1'b0); step(1);
    push(8'hA5, 3'd5, 1'b0); step(1);
    push(8'hA2, 3'd2, 1'b0); step(1);
    push(8'hA5, 3'd5, 1'b0); step(1);
    b8.mode = 1'b0; b8.sel = 3'd3;
    push(8'h00, 3'd3, 1'b1); step(1);
    b8.sel = 3'd5;
    push(8'hA5, 3'd5, 1'b0); step(1);
    b8.mode = 1'b1; b8.ch_mask = 8'h00;
    step(2);
    chk("mask0_valid", 32'(b8.out_valid), 32'd0);
    b8.ch_mask = 8'hFF; b8.mode = 1'b0;
`endif

    b8.en = 1'b0;
    step(2);
    chk("end_valid", 32'(b8.out_valid), 32'd0);
    chk("end_queue", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
